// File: rtl/lockstep_add_pipe.sv
// Multi-lane add-constant valid/ready pipeline with a lockstep checker that
// compares every lane against lane 0 on each output transfer.
module lockstep_add_pipe #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int STAGES   = 1,
    parameter int ADDEND   = 5,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic                      clear_err,
    output logic                      mismatch,
    output logic                      mismatch_sticky,
    output logic [CNT_W-1:0]          mismatch_count
);

    localparam int               DW      = CHANNELS * WIDTH;
    localparam logic [WIDTH-1:0] ADD_C   = WIDTH'(ADDEND);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DW-1:0]   stage_data [1:STAGES];
    logic [STAGES:1] stage_valid;
    logic [STAGES:1] load;
    logic [DW-1:0]   in_sum;
    logic            xfer;
    logic            neq;
    logic            hit;
    logic [CNT_W-1:0] count_base;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        in_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_sum[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH] + ADD_C;
        end
    end

    // Closed form of the ready ripple: a stage may load unless it and every
    // stage downstream of it are full while the output is stalled.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        load     = '0;
        for (int k = STAGES; k >= 1; k--) begin
            all_full = all_full && stage_valid[k];
            load[k]  = out_ready || !all_full;
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        logic [DW-1:0] d_in;
        logic          v_in;
        logic [DW-1:0] d_q;
        logic          v_q;

        if (k == 1) begin : g_first
            assign d_in = in_sum;
            assign v_in = in_valid;
        end else begin : g_rest
            assign d_in = stage_data[k-1];
            assign v_in = stage_valid[k-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (load[k]) begin
                v_q <= v_in;
                d_q <= d_in;
            end
        end

        assign stage_valid[k] = v_q;
        assign stage_data[k]  = d_q;
    end

    assign out_valid = stage_valid[STAGES];
    assign out_data  = stage_data[STAGES];
    assign in_ready  = load[1];
    assign xfer      = out_valid && out_ready;

    always_comb begin
        neq = 1'b0;
        for (int i = 1; i < CHANNELS; i++) begin
            if (out_data[i*WIDTH +: WIDTH] != out_data[WIDTH-1:0]) begin
                neq = 1'b1;
            end
        end
    end

    assign hit = xfer && neq;

    // Clear takes effect before this cycle's mismatch so both can coincide.
    always_comb begin
        count_base = clear_err ? '0 : mismatch_count;
        count_next = count_base;
        if (hit && (count_base != CNT_MAX)) begin
            count_next = count_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch        <= 1'b0;
            mismatch_sticky <= 1'b0;
            mismatch_count  <= '0;
        end else begin
            mismatch        <= hit;
            mismatch_sticky <= (mismatch_sticky && !clear_err) || hit;
            mismatch_count  <= count_next;
        end
    end

endmodule

// File: tb/tb_lockstep_add_pipe.sv
// Randomised and directed bench for lockstep_add_pipe, checked against a
// queue-of-beats reference model of the pipeline and checker.
module tb_lockstep_add_pipe;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 2;
    localparam int STAGES   = 3;
    localparam int ADDEND   = 5;
    localparam int CNT_W    = 2;
    localparam int DW       = CHANNELS * WIDTH;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;
    logic             clear_err = 1'b0;
    logic             mismatch;
    logic             mismatch_sticky;
    logic [CNT_W-1:0] mismatch_count;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_seen = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            pos;
    } beat_t;

    beat_t q[$];
    logic  exp_mismatch = 1'b0;
    logic  exp_sticky   = 1'b0;
    int    exp_count    = 0;

    always #5 clk = ~clk;

    lockstep_add_pipe #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .STAGES  (STAGES),
        .ADDEND  (ADDEND),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .clear_err      (clear_err),
        .mismatch       (mismatch),
        .mismatch_sticky(mismatch_sticky),
        .mismatch_count (mismatch_count)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [DW-1:0] sumOf(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        longint unsigned s;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            s = longint'(d[i*WIDTH +: WIDTH]) + ADDEND;
            r[i*WIDTH +: WIDTH] = WIDTH'(s % (64'd1 << WIDTH));
        end
        return r;
    endfunction

    function automatic bit lanesDiffer(input logic [DW-1:0] d);
        bit diff = 0;
        for (int i = 1; i < CHANNELS; i++) begin
            if (d[i*WIDTH +: WIDTH] != d[WIDTH-1:0]) diff = 1;
        end
        return diff;
    endfunction

    function automatic bit modelReady(input bit ordy);
        return !(q.size() == STAGES && !ordy);
    endfunction

    // Beats advance toward the output whenever the slot ahead is free or
    // its occupant moves on; only the front beat can sit at the last slot.
    task automatic modelEdge();
        bit    rdy, xf, hit, moved_prev;
        int    old_prev;
        beat_t nq[$];
        beat_t nb;
        rdy = modelReady(out_ready);
        xf  = (q.size() > 0) && (q[0].pos == STAGES) && out_ready;
        hit = xf && lanesDiffer(q[0].data);
        moved_prev = 1;
        old_prev   = STAGES + 1;
        foreach (q[j]) begin
            beat_t b;
            int    old;
            bit    mv;
            b   = q[j];
            old = b.pos;
            if (old == STAGES) mv = out_ready;
            else               mv = (old + 1 < old_prev) || moved_prev;
            if (mv) b.pos = old + 1;
            moved_prev = mv;
            old_prev   = old;
            if (b.pos <= STAGES) nq.push_back(b);
        end
        if (in_valid && rdy) begin
            nb.data = sumOf(in_data);
            nb.pos  = 1;
            nq.push_back(nb);
        end
        q = nq;
        if (clear_err) begin
            exp_sticky = 0;
            exp_count  = 0;
        end
        exp_mismatch = hit;
        if (hit) begin
            exp_sticky = 1;
            if (exp_count < CNT_MAX) exp_count++;
        end
    endtask

    task automatic checkAll();
        bit ev;
        ev = (q.size() > 0) && (q[0].pos == STAGES);
        checkOutput("in_ready", in_ready, modelReady(out_ready));
        checkOutput("out_valid", out_valid, ev);
        if (ev) checkOutput("out_data", out_data, q[0].data);
        checkOutput("mismatch", mismatch, exp_mismatch);
        checkOutput("sticky", mismatch_sticky, exp_sticky);
        checkOutput("count", mismatch_count, exp_count);
    endtask

    task automatic applyStimulus(input bit vld, input logic [31:0] l0, input logic [31:0] l1,
                                 input bit ordy, input bit clr);
        in_valid  = vld;
        in_data   = {l1, l0};
        out_ready = ordy;
        clear_err = clr;
        @(negedge clk);
        checkAll();
        if (out_valid && out_ready) xfer_seen++;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_count", mismatch_count, 0);
        checkOutput("rst_sticky", mismatch_sticky, 0);
        checkOutput("rst_mismatch", mismatch, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        q.delete();
        exp_mismatch = 0;
        exp_sticky   = 0;
        exp_count    = 0;
        in_valid  = 1'b1;
        in_data   = {32'd9, 32'd1};
        out_ready = 1'b1;
        clear_err = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_no_capture", out_valid, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // Sends n beats honouring backpressure; lane values come from base + index.
    task automatic sendBeats(input int n, input logic [31:0] b0, input logic [31:0] b1, input bit ordy);
        int idx = 0;
        while (idx < n) begin
            bit rdy;
            rdy = modelReady(ordy);
            applyStimulus(1, b0 + 32'(idx), b1 + 32'(idx), ordy, 0);
            if (rdy) idx++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        bit          vld, pend, ordy, clr;

        #2;
        doReset();

        // Single beat, equal lanes
        applyStimulus(1, 10, 10, 1, 0);
        idle(2);
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_data", out_data, 64'h0000000F_0000000F);
        idle(1);
        checkOutput("t1_no_mismatch", mismatch, 0);
        idle(2);

        // Continuous stream through the wrap-around boundary
        xfer_seen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 32'hFFFFFFFE + 32'(i), 32'hFFFFFFFE + 32'(i), 1, 0);
            if (i == 2) checkOutput("t2_wrap", out_data, 64'h00000003_00000003);
        end
        idle(4);
        checkOutput("t2_xfers", xfer_seen, 10);

        // Backpressure: fill with out_ready low, then release
        for (int i = 0; i < 6; i++) applyStimulus(1, 100 + i, 100 + i, 0, 0);
        checkOutput("t3_full_ready", in_ready, 0);
        checkOutput("t3_full_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        checkOutput("t3_ready_comb", in_ready, 1);
        idle(5);

        // Three mismatching transfers, then clear with a fourth
        sendBeats(3, 7, 8, 1);
        idle(3);
        checkOutput("t4_count", mismatch_count, 3);
        checkOutput("t4_sticky", mismatch_sticky, 1);
        applyStimulus(1, 7, 8, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("t4_clr_count", mismatch_count, 1);
        checkOutput("t4_clr_sticky", mismatch_sticky, 1);
        checkOutput("t4_clr_pulse", mismatch, 1);
        idle(2);

        // Saturation then a clean transfer
        sendBeats(5, 20, 40, 1);
        idle(3);
        checkOutput("t5_sat", mismatch_count, CNT_MAX);
        applyStimulus(1, 3, 3, 1, 0);
        idle(4);
        checkOutput("t5_sat_hold", mismatch_count, CNT_MAX);
        checkOutput("t5_sticky_hold", mismatch_sticky, 1);

        // Reset with a full pipeline and count 2
        applyStimulus(0, 0, 0, 1, 1);
        sendBeats(2, 1, 2, 1);
        idle(3);
        checkOutput("t6_pre_count", mismatch_count, 2);
        sendBeats(3, 50, 60, 0);
        checkOutput("t6_pre_full", out_valid, 1);
        #2;
        doReset();
        applyStimulus(1, 4, 4, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t6_not_yet", out_valid, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t6_latency", out_valid, 1);
        checkOutput("t6_data", out_data, 64'h00000009_00000009);
        idle(1);
        checkOutput("t6_no_mismatch", mismatch, 0);

        // Random traffic with upstream holding refused beats
        pend = 0;
        a = 0;
        b = 0;
        vld = 0;
        for (int c = 0; c < 400; c++) begin
            ordy = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 15) == 0);
            if (!pend) begin
                vld = ($urandom_range(0, 2) != 0);
                a   = $urandom;
                if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
                b   = ($urandom_range(0, 1) == 1) ? a : $urandom;
            end
            pend = vld && !modelReady(ordy);
            applyStimulus(vld, a, b, ordy, clr);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
